// File: rtl/lb_equil_gen.sv
// D2Q9 equilibrium generator feeding the collide/stream init write port.
// Sequences a full-lattice rest fill or a per-frame boundary rewrite through one shared multiplier.
module lb_equil_gen #(
    parameter int                 NX     = 136,
    parameter int                 NY     = 72,
    parameter int                 JET_LO = 31,
    parameter int                 JET_HI = 39,
    parameter logic signed [26:0] RHO    = 27'sd33554432
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_full,
    input  logic        start_boundary,
    input  logic [26:0] u0,
    output logic [26:0] n0_init_data,
    output logic [26:0] nN_init_data,
    output logic [26:0] nS_init_data,
    output logic [26:0] nW_init_data,
    output logic [26:0] nE_init_data,
    output logic [26:0] nNW_init_data,
    output logic [26:0] nNE_init_data,
    output logic [26:0] nSW_init_data,
    output logic [26:0] nSE_init_data,
    output logic [26:0] ux_init_data,
    output logic [26:0] uy_init_data,
    output logic [13:0] write_address_init,
    output logic        start_init,
    input  logic        init_finish,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {S_IDLE, S_SEL, S_CALC, S_REQ, S_WLO, S_FIN} state_t;

    localparam logic signed [26:0] ONE   = 27'sd33554432;
    localparam logic signed [26:0] W9    = 27'sd3728270;
    localparam logic signed [26:0] W36   = 27'sd932067;
    localparam logic [7:0]         I_MAX = 8'(NX - 1);
    localparam logic [6:0]         J_MAX = 7'(NY - 1);
    localparam logic [6:0]         J_BMX = 7'(NY - 2);
    localparam logic [6:0]         J_LO  = 7'(JET_LO);
    localparam logic [6:0]         J_HI  = 7'(JET_HI);
    localparam logic [13:0]        NX_A  = 14'(NX);

    // Fixed-point product: the 28-bit {sign, p[51:25]} truncated to the 27-bit datapath.
    function automatic logic signed [26:0] mfix(input logic signed [26:0] a, input logic signed [26:0] b);
        logic signed [53:0] p;
        p = a * b;
        return 27'({p[53], p[51:25]});
    endfunction

    function automatic logic signed [26:0] m45(input logic signed [26:0] a);
        return (a <<< 2) + (a >>> 1);
    endfunction

    state_t             state_q;
    logic               full_q, part2_q;
    logic [7:0]         i_q;
    logic [6:0]         j_q;
    logic [3:0]         calc_q;
    logic [13:0]        addr_q;
    logic signed [26:0] u0_q, ux_q, uy_q, ux2_q, uy2_q, uxuy_q, r9_q, r36_q;
    logic signed [26:0] t_q [8];

    logic signed [26:0] sel_ux_s, sel_uy_s, half_s;
    logic [13:0]        addr_s;
    logic [7:0]         i_d;
    logic [6:0]         j_d;
    logic               part2_d, last_s;
    logic signed [26:0] u2_s, u215_s, x3_s, y3_s, uxuy2_s, mul_a_s, mul_b_s, mfix_s, n0_s;

    // Cell velocity, address, walk order and last-cell detect for the current job position.
    always_comb begin
        half_s   = u0_q >>> 1;
        sel_ux_s = u0_q;
        sel_uy_s = 27'sd0;
        addr_s   = {6'd0, i_q} + NX_A * {7'd0, j_q};
        i_d      = i_q;
        j_d      = j_q;
        part2_d  = part2_q;
        if (full_q) begin
            sel_ux_s = 27'sd0;
            last_s   = (i_q == I_MAX) && (j_q == J_MAX);
            if (i_q == I_MAX) begin
                i_d = 8'd0;
                j_d = j_q + 7'd1;
            end else begin
                i_d = i_q + 8'd1;
            end
        end else if (!part2_q) begin
            last_s = 1'b0;
            if (j_q == 7'd0) begin
                j_d = J_MAX;
            end else if (i_q == I_MAX) begin
                part2_d = 1'b1;
                i_d     = 8'd0;
                j_d     = 7'd1;
            end else begin
                i_d = i_q + 8'd1;
                j_d = 7'd0;
            end
        end else begin
            last_s = (i_q == I_MAX) && (j_q == J_BMX);
            if (i_q == 8'd0) begin
                i_d = I_MAX;
                if (j_q < J_LO) begin
                    sel_ux_s = 27'sd0;
                    sel_uy_s = half_s;
                end else if (j_q > J_HI) begin
                    sel_ux_s = 27'sd0;
                    sel_uy_s = 27'sd0 - half_s;
                end else begin
                    sel_uy_s = 27'sd0;
                end
            end else begin
                i_d = 8'd0;
                j_d = j_q + 7'd1;
            end
        end
    end

    // Shared multiplier operand schedule for the 13 multiply steps of CALC.
    always_comb begin
        u2_s    = ux2_q + uy2_q;
        u215_s  = u2_s + (u2_s >>> 1);
        x3_s    = (ux_q <<< 1) + ux_q;
        y3_s    = (uy_q <<< 1) + uy_q;
        uxuy2_s = uxuy_q <<< 1;
        mul_a_s = ux_q;
        mul_b_s = ux_q;
        case (calc_q)
            4'd0:  begin mul_a_s = ux_q; mul_b_s = ux_q; end
            4'd1:  begin mul_a_s = uy_q; mul_b_s = uy_q; end
            4'd2:  begin mul_a_s = ux_q; mul_b_s = uy_q; end
            4'd3:  begin mul_a_s = W9;   mul_b_s = RHO;  end
            4'd4:  begin mul_a_s = W36;  mul_b_s = RHO;  end
            4'd5:  begin mul_a_s = r9_q;  mul_b_s = ONE + x3_s + m45(ux2_q) - u215_s; end
            4'd6:  begin mul_a_s = r9_q;  mul_b_s = ONE - x3_s + m45(ux2_q) - u215_s; end
            4'd7:  begin mul_a_s = r9_q;  mul_b_s = ONE + y3_s + m45(uy2_q) - u215_s; end
            4'd8:  begin mul_a_s = r9_q;  mul_b_s = ONE - y3_s + m45(uy2_q) - u215_s; end
            4'd9:  begin mul_a_s = r36_q; mul_b_s = ONE + x3_s + y3_s + m45(u2_s + uxuy2_s) - u215_s; end
            4'd10: begin mul_a_s = r36_q; mul_b_s = ONE + x3_s - y3_s + m45(u2_s - uxuy2_s) - u215_s; end
            4'd11: begin mul_a_s = r36_q; mul_b_s = ONE - x3_s + y3_s + m45(u2_s - uxuy2_s) - u215_s; end
            4'd12: begin mul_a_s = r36_q; mul_b_s = ONE - x3_s - y3_s + m45(u2_s + uxuy2_s) - u215_s; end
            default: begin mul_a_s = ux_q; mul_b_s = ux_q; end
        endcase
        mfix_s = mfix(mul_a_s, mul_b_s);
        n0_s   = RHO - (t_q[0] + t_q[1] + t_q[2] + t_q[3] + t_q[4] + t_q[5] + t_q[6] + t_q[7]);
    end

    // Job sequencer with registered handshake and data outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            full_q <= 1'b0; part2_q <= 1'b0; i_q <= 8'd0; j_q <= 7'd0; calc_q <= 4'd0; addr_q <= 14'd0;
            u0_q <= 27'sd0; ux_q <= 27'sd0; uy_q <= 27'sd0; ux2_q <= 27'sd0; uy2_q <= 27'sd0;
            uxuy_q <= 27'sd0; r9_q <= 27'sd0; r36_q <= 27'sd0;
            for (int k = 0; k < 8; k++) t_q[k] <= 27'sd0;
            n0_init_data <= 27'd0; nN_init_data <= 27'd0; nS_init_data <= 27'd0; nW_init_data <= 27'd0;
            nE_init_data <= 27'd0; nNW_init_data <= 27'd0; nNE_init_data <= 27'd0; nSW_init_data <= 27'd0;
            nSE_init_data <= 27'd0; ux_init_data <= 27'd0; uy_init_data <= 27'd0;
            write_address_init <= 14'd0; start_init <= 1'b0; busy <= 1'b0; done <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start_full || start_boundary) begin
                        full_q  <= start_full;
                        u0_q    <= $signed(u0);
                        i_q     <= 8'd0;
                        j_q     <= 7'd0;
                        part2_q <= 1'b0;
                        busy    <= 1'b1;
                        state_q <= S_SEL;
                    end
                end
                S_SEL: begin
                    ux_q    <= sel_ux_s;
                    uy_q    <= sel_uy_s;
                    addr_q  <= addr_s;
                    calc_q  <= 4'd0;
                    state_q <= S_CALC;
                end
                S_CALC: begin
                    calc_q <= calc_q + 4'd1;
                    case (calc_q)
                        4'd0:  ux2_q  <= mfix_s;
                        4'd1:  uy2_q  <= mfix_s;
                        4'd2:  uxuy_q <= mfix_s;
                        4'd3:  r9_q   <= mfix_s;
                        4'd4:  r36_q  <= mfix_s;
                        4'd5:  t_q[0] <= mfix_s;
                        4'd6:  t_q[1] <= mfix_s;
                        4'd7:  t_q[2] <= mfix_s;
                        4'd8:  t_q[3] <= mfix_s;
                        4'd9:  t_q[4] <= mfix_s;
                        4'd10: t_q[5] <= mfix_s;
                        4'd11: t_q[6] <= mfix_s;
                        4'd12: t_q[7] <= mfix_s;
                        4'd13: begin
                            n0_init_data  <= n0_s;
                            nE_init_data  <= t_q[0];
                            nW_init_data  <= t_q[1];
                            nN_init_data  <= t_q[2];
                            nS_init_data  <= t_q[3];
                            nNE_init_data <= t_q[4];
                            nSE_init_data <= t_q[5];
                            nNW_init_data <= t_q[6];
                            nSW_init_data <= t_q[7];
                            ux_init_data  <= ux_q;
                            uy_init_data  <= uy_q;
                            write_address_init <= addr_q;
                            start_init    <= 1'b1;
                            state_q       <= S_REQ;
                        end
                        default: state_q <= S_IDLE;
                    endcase
                end
                S_REQ: begin
                    if (init_finish) begin
                        start_init <= 1'b0;
                        state_q    <= S_WLO;
                    end
                end
                S_WLO: begin
                    if (!init_finish) begin
                        if (last_s) begin
                            state_q <= S_FIN;
                        end else begin
                            i_q     <= i_d;
                            j_q     <= j_d;
                            part2_q <= part2_d;
                            state_q <= S_SEL;
                        end
                    end
                end
                S_FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/lb_equil_gen.md
Name: lb_equil_gen

Overview:
- Hardware equilibrium-distribution generator sitting directly upstream of collide_stream_fsm, driving its init write port (n*_init_data, ux/uy_init_data, write_address_init, start_init/init_finish).
- Two sequenced jobs:
  - FULL: writes rest equilibrium to every cell of the 136x72 lattice.
  - BOUNDARY: rewrites the inlet/outlet/wall boundary cells each frame.
- Arithmetic is 27-bit signed fixed point with 25 fraction bits (1.0 = 33554432), computed with one shared multiplier.

Parameters:
- NX, 136, lattice width in cells.
- NY, 72, lattice height in cells.
- JET_LO, 31, first left-column row driven with +x inflow.
- JET_HI, 39, last left-column row driven with +x inflow.
- RHO, 33554432, density for every generated cell (fixed 1.0).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset.
- start_full  in  1  one-cycle pulse, starts FULL job.
- start_boundary  in  1  one-cycle pulse, starts BOUNDARY job.
- u0  in  27  signed inflow speed; sampled at job start.
- n0_init_data, nN_init_data, nS_init_data, nW_init_data, nE_init_data, nNW_init_data, nNE_init_data, nSW_init_data, nSE_init_data  out  27 each  signed distributions.
- ux_init_data, uy_init_data  out  27 each  signed cell velocity.
- write_address_init  out  14  cell address, i + NX*j.
- start_init  out  1  write request to collide_stream_fsm.
- init_finish  in  1  write acknowledge from collide_stream_fsm.
- busy  out  1  high from job accept until done.
- done  out  1  one-cycle pulse after last cell acknowledged.

Behaviour:
- Reset (rst==0 at clk edge): state IDLE; all data outputs, address, start_init, busy and done are 0. Reset mid-job aborts immediately; no partial handshake is resumed.
- States: IDLE -> SEL -> CALC -> REQ -> WLO -> (SEL | FIN) -> IDLE.
- IDLE:
  - start_full takes priority if both starts are high.
  - Latch u0, clear cell index, set busy, go to SEL.
  - Starts while busy are ignored.
- SEL: derive (i, j, ux, uy) from the job and cell index.
  - FULL: row-major, j = 0..NY-1, i = 0..NX-1, ux = uy = 0; 9792 cells.
  - BOUNDARY, part 1: for i = 0..NX-1, emit (i,0) then (i,NY-1); ux = u0, uy = 0.
  - BOUNDARY, part 2: for j = 1..NY-2, emit (0,j) then (NX-1,j). 412 cells total.
  - Left-column velocity: ux = u0, uy = 0 for JET_LO <= j <= JET_HI; ux = 0, uy = u0>>>1 for j < JET_LO; ux = 0, uy = -(u0>>>1) for j > JET_HI.
  - Right column: ux = u0, uy = 0.
- CALC: one registered multiply per cycle, 13 cycles, then one n0 cycle (14 cycles total).
  - mFix(a,b) = {p[53], p[51:25]} of the 54-bit signed product p = a*b.
  - Multiply order: ux2 = mFix(ux,ux); uy2; uxuy = mFix(ux,uy); r9 = mFix(3728270,RHO); r36 = mFix(932067,RHO); then the eight directional terms.
  - Derived terms: u2 = ux2 + uy2; u215 = u2 + (u2>>>1); x3 = 3*ux; y3 = 3*uy; m45(a) = (a<<<2) + (a>>>1); uxuy2 = uxuy<<<1.
  - nE/nW = mFix(r9, 1.0 ± x3 + m45(ux2) - u215).
  - nN/nS = mFix(r9, 1.0 ± y3 + m45(uy2) - u215).
  - nNE = mFix(r36, 1.0 + x3 + y3 + m45(u2 + uxuy2) - u215).
  - nSE = mFix(r36, 1.0 + x3 - y3 + m45(u2 - uxuy2) - u215).
  - nNW = mFix(r36, 1.0 - x3 + y3 + m45(u2 - uxuy2) - u215).
  - nSW = mFix(r36, 1.0 - x3 - y3 + m45(u2 + uxuy2) - u215).
  - n0 = RHO - (sum of the eight values just computed for this cell). All sums wrap at 27 bits.
- REQ:
  - Data outputs and address update on REQ entry and stay stable until the next REQ.
  - start_init is high throughout REQ.
  - On init_finish==1, drop start_init the next cycle and go to WLO.
- WLO: wait for init_finish==0.
  - Last cell: go to FIN. Otherwise increment index and go to SEL.
- FIN: pulse done for one cycle, clear busy, go to IDLE.
- No timeout. A stuck init_finish holds the block in REQ or WLO.

Test Plan:
- FULL, RHO = 1.0 -> exactly 9792 start_init handshakes at addresses 0..9791 in order; every cell has nE=nW=nN=nS=3728270, nNE=nNW=nSE=nSW=932067, n0=14913084, ux=uy=0; then one done pulse.
- BOUNDARY, u0=2684354 -> 412 handshakes; addresses 0, 9656, 1, 9657, ..., 135, 9791, 136, 271, ..., 9520, 9655; top/bottom rows have ux=2684354, uy=0, nE>nW.
- Left column, u0=2684354 -> addr 1360 (j=10): ux=0, uy=1342177; addr 4760 (j=35): ux=2684354, uy=0; addr 6800 (j=50): uy=-1342177. Every cell satisfies sum of nine outputs == 33554432.
- Acknowledge delayed 7 cycles and held 3 cycles -> outputs stable while start_init is high; start_init falls the cycle after init_finish rises; no re-request until init_finish is low.
- start_full and start_boundary pulsed in the same cycle -> FULL runs. start_boundary mid-FULL -> ignored, FULL count remains 9792.
- rst=0 during REQ at cell 5 -> start_init, busy = 0 next edge; a following start_boundary restarts from address 0.
